// File: rtl/hamming_enc_arbiter_pkg.sv
// hamming_pkg: Hamming(7,4) widths, parity positions and encode function.
// HAMMING_SECDED_EN adds an eighth even-parity bit over the 7-bit codeword.
package hamming_pkg;
`ifdef HAMMING_SECDED_EN
  localparam int CW_W = 8;
`else
  localparam int CW_W = 7;
`endif
  localparam int P0_POS = 0;
  localparam int P1_POS = 1;
  localparam int P2_POS = 3;
  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] c;
    c = {d[3], d[2], d[1], 1'b0, d[0], 2'b00};
    c[P0_POS] = d[0] ^ d[1] ^ d[3];
    c[P1_POS] = d[0] ^ d[2] ^ d[3];
    c[P2_POS] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction
endpackage

// File: rtl/hamming_enc_arbiter_if.sv
// hamming_enc_arbiter_if: requester and output-slot handshake bundle.
interface hamming_enc_arbiter_if #(parameter int N_REQ = 4);
  import hamming_pkg::*;
  localparam int SRC_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [4*N_REQ-1:0] req_data;
  logic out_valid;
  logic out_ready;
  logic [CW_W-1:0] out_data;
  logic [SRC_W-1:0] out_src;
  modport master(output req_valid, req_data, out_ready, input req_ready, out_valid, out_data, out_src);
  modport slave(input req_valid, req_data, out_ready, output req_ready, out_valid, out_data, out_src);
endinterface

// File: rtl/hamming_enc_arbiter_enc.sv
// hamming74_enc: combinational nibble encoder, optional overall parity bit (HAMMING_SECDED_EN).
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [3:0]      d,
  output logic [CW_W-1:0] cw
);
`ifdef HAMMING_SECDED_EN
  assign cw = {^enc7(d), enc7(d)};
`else
  assign cw = enc7(d);
`endif
endmodule

// File: rtl/hamming_enc_arbiter.sv
// hamming_enc_arbiter: round-robin share of one Hamming encoder among N_REQ producers.
// Output width grows to 8 bits when HAMMING_SECDED_EN is defined.
module hamming_enc_arbiter
  import hamming_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  hamming_enc_arbiter_if.slave bus,
  output logic             busy,
  output logic [CNT_W-1:0] cw_count
);
  localparam int SRC_W = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [SRC_W-1:0] rr_ptr, g;
  logic found, load_ok, accept;
  logic [3:0] nib;
  logic [CW_W-1:0] cw;
  always_comb begin
    g = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        g = SRC_W'((int'(rr_ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end
  // rst_n gating keeps any handshake from completing while reset is held
  assign load_ok = rst_n & enable & (!bus.out_valid | bus.out_ready);
  assign accept = load_ok & found;
  assign bus.req_ready = accept ? N_REQ'(1) << g : '0;
  assign nib = bus.req_data[{g, 2'b00} +: 4];
  assign busy = bus.out_valid;
  hamming74_enc u_enc (.d(nib), .cw(cw));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.out_src <= '0;
      rr_ptr <= '0;
      cw_count <= '0;
    end else begin
      if (accept) begin
        bus.out_data <= cw;
        bus.out_src <= g;
        rr_ptr <= (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
        cw_count <= cw_count + {{(CNT_W-1){1'b0}}, ~&cw_count};
      end
      bus.out_valid <= accept | (bus.out_valid & !bus.out_ready);
    end
  end
endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb_hamming_enc_arbiter: directed and random checks against a cycle-level reference model.
module tb_hamming_enc_arbiter;
  localparam int N = 4;
  localparam int CNTW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic busy;
  logic [CNTW-1:0] cw_count;
  int tests = 0;
  int fails = 0;
  int m_ptr, m_src, m_cnt;
  logic m_ov;
  logic [7:0] m_od;
  logic [7:0] hold;
  logic [4*N-1:0] rd;

  hamming_enc_arbiter_if #(.N_REQ(N)) bus();
  hamming_enc_arbiter #(.N_REQ(N), .CNT_W(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus), .busy(busy), .cw_count(cw_count)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hamming code by definition: data at non-power-of-two positions 1..7,
  // parity at position 2^i covers every position with bit i set.
  function automatic logic [7:0] ref_enc(input logic [3:0] d);
    logic [7:0] c;
    int j;
    c = '0;
    j = 0;
    for (int p = 1; p <= 7; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        j++;
      end
    for (int i = 0; i < 3; i++)
      for (int p = 1; p <= 7; p++)
        if (p[i] && p != (1 << i)) c[(1 << i) - 1] ^= c[p-1];
`ifdef HAMMING_SECDED_EN
    c[7] = ^c[6:0];
`endif
    return c;
  endfunction

  task automatic mreset();
    m_ov = 1'b0;
    m_od = '0;
    m_src = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask

  task automatic outs(input string tag);
    chk({tag, ".valid"}, bus.out_valid, m_ov);
    chk({tag, ".busy"}, busy, m_ov);
    chk({tag, ".data"}, bus.out_data, m_od);
    chk({tag, ".src"}, bus.out_src, m_src);
    chk({tag, ".cnt"}, cw_count, m_cnt);
  endtask

  // Called just after a falling edge; runs one clock cycle.
  task automatic step(input logic en, input logic [N-1:0] v, input logic [4*N-1:0] d,
                      input logic ordy, input string tag);
    int g;
    logic [N-1:0] er;
    enable = en;
    bus.req_valid = v;
    bus.req_data = d;
    bus.out_ready = ordy;
    #1;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    er = '0;
    if (en && (!m_ov || ordy) && g >= 0) er[g] = 1'b1;
    chk({tag, ".rdy"}, bus.req_ready, er);
    @(posedge clk);
    #1;
    if (er != '0) begin
      m_od = ref_enc(d[4*g +: 4]);
      m_src = g;
      m_ptr = (g + 1) % N;
      m_cnt = (m_cnt == (1 << CNTW) - 1) ? m_cnt : m_cnt + 1;
    end
    m_ov = (er != '0) || (m_ov && !ordy);
    outs(tag);
    @(negedge clk);
  endtask

  initial begin
    mreset();
    enable = 1'b1;
    bus.req_valid = '1;
    bus.req_data = 16'h1234;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    outs("reset");
    chk("reset.rdy", bus.req_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, 4'b0001, 16'h000B, 1'b1, "single");
    chk("single.const_data", bus.out_data, 8'h55);
    chk("single.const_src", bus.out_src, 0);
    chk("single.const_cnt", cw_count, 1);

    // reset while the slot is full
    rst_n = 1'b0;
    bus.req_valid = '1;
    #1;
    chk("midrst.valid", bus.out_valid, 0);
    chk("midrst.data", bus.out_data, 0);
    chk("midrst.cnt", cw_count, 0);
    chk("midrst.rdy", bus.req_ready, 0);
    @(posedge clk);
    #1;
    chk("midrst.noload", bus.out_valid, 0);
    mreset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'b1111, 16'h7E15, 1'b1, "rr");
      chk("rr.seq", bus.out_src, i % 4);
    end

    hold = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111, 16'h9C3A, 1'b0, "bp");
      chk("bp.hold", bus.out_data, hold);
    end
    step(1'b1, 4'b1111, 16'h9C3A, 1'b1, "bp_release");
    chk("bp_release.src", bus.out_src, 1);
    chk("bp_release.data", bus.out_data, ref_enc(4'h3));

    step(1'b0, 4'b1111, 16'h5A5A, 1'b1, "dis");
    chk("dis.drained", bus.out_valid, 0);
    step(1'b0, 4'b1111, 16'h5A5A, 1'b1, "dis2");
    step(1'b1, 4'b1111, 16'h5A5A, 1'b1, "reen");
    chk("reen.src", bus.out_src, 2);

    for (int i = 0; i < 400; i++) begin
      rd = 16'($urandom);
      step(($urandom_range(0, 7) != 0), 4'($urandom), rd, ($urandom_range(0, 3) != 0), "rand");
    end
    chk("sat.cnt", cw_count, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/hamming_enc_arbiter.md
# hamming_enc_arbiter

Round-robin arbiter and sequencer that shares a single Hamming(7,4) encoder among N_REQ nibble producers. Each requester offers a 4-bit data nibble over a valid/ready handshake. The winner's nibble is encoded and registered into a single output slot, tagged with the source index, and drained over a valid/ready handshake to the downstream channel/serializer. A saturating counter reports the number of codewords produced.

## Interface
- N_REQ, 4, number of requesters (legal 2..8)
- CNT_W, 16, width of codeword counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = grants allowed; 0 = no new grants, pending output still drains
- req_valid  in  N_REQ  per-requester nibble valid
- req_data  in  N_REQ*4  nibble of requester i at [4i+3:4i]
- req_ready  out  N_REQ  one-hot-or-zero accept strobe
- out_valid  out  1  output slot holds a codeword
- out_data  out  CW_W  codeword; CW_W = 7 (8 with HAMMING_SECDED_EN)
- out_src  out  SRC_W  index of granted requester; SRC_W = max(1,$clog2(N_REQ))
- out_ready  in  1  downstream accept
- busy  out  1  equals out_valid
- cw_count  out  CNT_W  saturating count of accepted nibbles

## Operation
- Encoding of nibble d[3:0]: p0=d0^d1^d3, p1=d0^d2^d3, p2=d1^d2^d3; codeword[6:0]={d3,d2,d1,p2,d0,p1,p0}.
- Slot load condition: load_ok = enable & (!out_valid | out_ready).
- Arbitration: when load_ok and any req_valid, grant the first valid index searching rr_ptr, rr_ptr+1, … modulo N_REQ. req_ready[g]=1 only for winner g; it is combinational from req_valid, rr_ptr, out_valid, out_ready, enable.
- On accept (req_valid[g]&req_ready[g]) at edge:
  - out_data ← enc(req_data[g])
  - out_src ← g
  - out_valid ← 1
  - rr_ptr ← (g+1) mod N_REQ
  - cw_count ← cw_count+1, saturating at all-ones
- Drain: out_valid&out_ready with no accept in the same cycle → out_valid←0. Drain and accept in the same cycle → slot reloads, out_valid stays 1 (back-to-back, one codeword/cycle).
- out_valid=1 & out_ready=0 → out_data/out_src held stable, all req_ready=0.
- Requesters hold req_valid/req_data until accepted. Deasserting before accept is legal; that requester is simply not granted.
- enable=0: req_ready all 0, rr_ptr frozen, slot drains normally.
- rr_ptr advances only on grant. No grant leaves it unchanged.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, req_ready=0, busy=0, cw_count=0, rr_ptr=0. All registers clear asynchronously on rst_n low.
- Reset mid-operation discards the slot contents. No handshake completes in a cycle where rst_n is low.
- Latency: accept at edge k → out_valid=1 with the codeword after edge k.
- Throughput: 1 codeword/cycle under continuous out_ready.
- Fairness: under continuous all-valid, each requester is granted exactly once per N_REQ grants.
- No combinational path from out_data to any input; out_ready→req_ready is combinational.

## Configuration
- HAMMING_SECDED_EN defined: CW_W=8. out_data[7] = XOR of codeword[6:0] (even overall parity), bits [6:0] unchanged.
- Undefined: CW_W=7, no bit 7.

## Structure
- Package hamming_pkg:
  - codeword width localparams (CW_W selected by HAMMING_SECDED_EN)
  - parity bit position constants
  - pure function for the 7-bit encode
- Sub-module hamming74_enc (combinational, 4-bit in → CW_W out) instanced once on the muxed winner nibble.
- Arbiter, slot register and counter live in the top.

## Test plan
- Reset: assert rst_n=0 mid-transfer with out_valid=1 → all outputs 0 immediately. After release, first grant goes to requester 0.
- Single request: req_valid=0001, req_data[3:0]=4'b1011, out_ready=1 → req_ready=0001 for one cycle. Next cycle out_valid=1, out_data=7'h55, out_src=0, cw_count=1.
- All valid, out_ready=1 for 5 accepts → out_src sequence 0,1,2,3,0 on consecutive cycles.
- Backpressure: slot full, out_ready=0 for 3 cycles → out_data stable, req_ready=0. Raise out_ready → the same cycle grants the next rr index and reloads the slot.
- enable=0 with req_valid=1111 and slot full, out_ready=1 → slot drains, no grants, rr_ptr unchanged. Re-enable → grant resumes at the held rr_ptr.
- With HAMMING_SECDED_EN: nibble 4'b0001 → out_data=8'h87; nibble 4'b1011 → 8'h55. Also preload cw_count to all-ones and accept once → stays all-ones.
